// File: rtl/byte_reg_file.sv
// Bank of CPU byte registers with one load/transfer/inc/dec/push/pop operation per cycle,
// registered Z/N flag results, a stack-wrap pulse, an op-reject pulse and two read ports.
module byte_reg_file #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SP_INDEX = 3,
    parameter logic [WIDTH-1:0] SP_RESET = 8'hFD,
    localparam int SELW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_op_valid,
    input  logic [2:0]       i_op,
    input  logic [SELW-1:0]  i_dst_sel,
    input  logic [SELW-1:0]  i_src_sel,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [SELW-1:0]  i_rd_sel_a,
    input  logic [SELW-1:0]  i_rd_sel_b,
    output logic [WIDTH-1:0] o_rd_data_a,
    output logic [WIDTH-1:0] o_rd_data_b,
    output logic             o_flag_upd,
    output logic             o_flag_z,
    output logic             o_flag_n,
    output logic             o_sp_wrap,
    output logic             o_op_err
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_XFER = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_PUSH = 3'd5,
        OP_POP  = 3'd6,
        OP_RSVD = 3'd7
    } opType;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_flagUpd;
    logic             r_flagZ;
    logic             r_flagN;
    logic             r_spWrap;
    logic             r_opErr;

    opType            w_op;
    logic             w_dstOk;
    logic             w_srcOk;
    logic             w_dstIsSp;
    logic [WIDTH-1:0] w_dstVal;
    logic [WIDTH-1:0] w_srcVal;
    logic [WIDTH-1:0] w_spVal;
    logic             w_write;
    logic [SELW-1:0]  w_wrIdx;
    logic [WIDTH-1:0] w_wrVal;
    logic             w_flagUpd;
    logic             w_wrap;
    logic             w_reject;

    assign w_op      = opType'(i_op);
    assign w_dstOk   = 32'(i_dst_sel) < NREGS;
    assign w_srcOk   = 32'(i_src_sel) < NREGS;
    assign w_dstIsSp = 32'(i_dst_sel) == SP_INDEX;
    assign w_dstVal  = w_dstOk ? r_regs[i_dst_sel] : '0;
    assign w_srcVal  = w_srcOk ? r_regs[i_src_sel] : '0;
    assign w_spVal   = r_regs[SP_INDEX];

    // Decode the requested operation into a single register write plus flag/pulse requests.
    always_comb begin
        w_write   = 1'b0;
        w_wrIdx   = i_dst_sel;
        w_wrVal   = '0;
        w_flagUpd = 1'b0;
        w_wrap    = 1'b0;
        w_reject  = 1'b0;
        if (i_op_valid) begin
            case (w_op)
                OP_LOAD: begin
                    if (!w_dstOk) begin
                        w_reject = 1'b1;
                    end else begin
                        w_write   = 1'b1;
                        w_wrVal   = i_wr_data;
                        w_flagUpd = 1'b1;
                    end
                end
                OP_XFER: begin
                    if (!w_dstOk || !w_srcOk) begin
                        w_reject = 1'b1;
                    end else begin
                        w_write   = 1'b1;
                        w_wrVal   = w_srcVal;
                        w_flagUpd = !w_dstIsSp;
                    end
                end
                OP_INC, OP_DEC: begin
                    if (!w_dstOk) begin
                        w_reject = 1'b1;
                    end else begin
                        w_write   = 1'b1;
                        w_wrVal   = (w_op == OP_INC) ? w_dstVal + 1'b1 : w_dstVal - 1'b1;
                        w_flagUpd = 1'b1;
                    end
                end
                OP_PUSH: begin
                    w_write = 1'b1;
                    w_wrIdx = SELW'(SP_INDEX);
                    w_wrVal = w_spVal - 1'b1;
                    w_wrap  = (w_spVal == '0);
                end
                OP_POP: begin
                    w_write = 1'b1;
                    w_wrIdx = SELW'(SP_INDEX);
                    w_wrVal = w_spVal + 1'b1;
                    w_wrap  = (w_spVal == '1);
                end
                OP_RSVD: begin
                    w_reject = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // State update: flags follow the written value only for flag-updating ops; pulses last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
            r_flagUpd <= 1'b0;
            r_flagZ   <= 1'b0;
            r_flagN   <= 1'b0;
            r_spWrap  <= 1'b0;
            r_opErr   <= 1'b0;
        end else begin
            if (w_write) begin
                r_regs[w_wrIdx] <= w_wrVal;
            end
            if (w_flagUpd) begin
                r_flagZ <= (w_wrVal == '0);
                r_flagN <= w_wrVal[WIDTH-1];
            end
            r_flagUpd <= w_flagUpd;
            r_spWrap  <= w_wrap;
            r_opErr   <= w_reject;
        end
    end

    // Read ports see committed state only; an out-of-range select reads as zero.
    assign o_rd_data_a = (32'(i_rd_sel_a) < NREGS) ? r_regs[i_rd_sel_a] : '0;
    assign o_rd_data_b = (32'(i_rd_sel_b) < NREGS) ? r_regs[i_rd_sel_b] : '0;

    assign o_flag_upd = r_flagUpd;
    assign o_flag_z   = r_flagZ;
    assign o_flag_n   = r_flagN;
    assign o_sp_wrap  = r_spWrap;
    assign o_op_err   = r_opErr;

endmodule

// File: tb/tb_byte_reg_file.sv
// Bench for byte_reg_file: directed scenarios with literal expectations, then random ops
// checked every cycle against an arithmetic model of the register bank.
module tb_byte_reg_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       opValid;
    logic [2:0] op;
    logic [1:0] dstSel, srcSel, rdSelA, rdSelB;
    logic [7:0] wrData;
    logic [7:0] rdDataA, rdDataB;
    logic       flagUpd, flagZ, flagN, spWrap, opErr;

    logic       bValid;
    logic [2:0] bOp;
    logic [1:0] bDst, bSrc, bRdA, bRdB;
    logic [7:0] bData;
    logic [7:0] bRdDataA, bRdDataB;
    logic       bFlagUpd, bFlagZ, bFlagN, bSpWrap, bOpErr;

    byte_reg_file dut (
        .clk(clk), .rst(rst),
        .i_op_valid(opValid), .i_op(op), .i_dst_sel(dstSel), .i_src_sel(srcSel),
        .i_wr_data(wrData), .i_rd_sel_a(rdSelA), .i_rd_sel_b(rdSelB),
        .o_rd_data_a(rdDataA), .o_rd_data_b(rdDataB),
        .o_flag_upd(flagUpd), .o_flag_z(flagZ), .o_flag_n(flagN),
        .o_sp_wrap(spWrap), .o_op_err(opErr)
    );

    byte_reg_file #(.NREGS(3), .SP_INDEX(2)) dutSmall (
        .clk(clk), .rst(rst),
        .i_op_valid(bValid), .i_op(bOp), .i_dst_sel(bDst), .i_src_sel(bSrc),
        .i_wr_data(bData), .i_rd_sel_a(bRdA), .i_rd_sel_b(bRdB),
        .o_rd_data_a(bRdDataA), .o_rd_data_b(bRdDataB),
        .o_flag_upd(bFlagUpd), .o_flag_z(bFlagZ), .o_flag_n(bFlagN),
        .o_sp_wrap(bSpWrap), .o_op_err(bOpErr)
    );

    int nVectors = 0;
    int nChecks  = 0;
    int nMis     = 0;

    // Reference model: register contents as plain integers, flags and pulses as bits.
    int mRegs [4];
    bit mZ, mN, mUpd, mWrap, mErr;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRegs = '{0, 0, 0, 253};
        mZ = 0; mN = 0; mUpd = 0; mWrap = 0; mErr = 0;
    endtask

    // Drive one op, advance a clock, then update the model from the op's arithmetic meaning.
    task automatic applyStimulus(input bit v, input logic [2:0] o, input logic [1:0] d,
                                 input logic [1:0] s, input logic [7:0] data,
                                 input logic [1:0] ra, input logic [1:0] rb);
        int nRegs [4];
        int res;
        bit upd, wrap, err, nz, nn;
        opValid = v; op = o; dstSel = d; srcSel = s; wrData = data;
        rdSelA = ra; rdSelB = rb;
        nRegs = mRegs;
        res = 0; upd = 0; wrap = 0; err = 0; nz = mZ; nn = mN;
        if (v) begin
            case (int'(o))
                1: begin
                    if (int'(d) >= 4) err = 1;
                    else begin res = int'(data); nRegs[d] = res; upd = 1; end
                end
                2: begin
                    if (int'(d) >= 4 || int'(s) >= 4) err = 1;
                    else begin res = mRegs[s]; nRegs[d] = res; upd = (int'(d) != 3); end
                end
                3: begin res = (mRegs[d] + 1) % 256; nRegs[d] = res; upd = 1; end
                4: begin res = (mRegs[d] + 255) % 256; nRegs[d] = res; upd = 1; end
                5: begin wrap = (mRegs[3] == 0); nRegs[3] = (mRegs[3] + 255) % 256; end
                6: begin wrap = (mRegs[3] == 255); nRegs[3] = (mRegs[3] + 1) % 256; end
                7: err = 1;
                default: ;
            endcase
        end
        if (upd) begin
            nz = (res == 0);
            nn = (res >= 128);
        end
        nVectors++;
        @(posedge clk);
        #1;
        mRegs = nRegs; mZ = nz; mN = nn; mUpd = upd; mWrap = wrap; mErr = err;
        @(negedge clk);
        #1;
    endtask

    // Every falling edge compares all main-DUT outputs with the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rdA", 32'(rdDataA), mRegs[rdSelA]);
            checkOutput("rdB", 32'(rdDataB), mRegs[rdSelB]);
            checkOutput("flagZ", 32'(flagZ), 32'(mZ));
            checkOutput("flagN", 32'(flagN), 32'(mN));
            checkOutput("flagUpd", 32'(flagUpd), 32'(mUpd));
            checkOutput("spWrap", 32'(spWrap), 32'(mWrap));
            checkOutput("opErr", 32'(opErr), 32'(mErr));
        end
    end

    initial begin
        logic [7:0] picks [5];
        logic [7:0] data;
        logic [2:0] o;
        logic [1:0] d;
        picks = '{8'h00, 8'hFF, 8'h01, 8'h7F, 8'h80};

        rst = 1'b1;
        opValid = 0; op = 0; dstSel = 0; srcSel = 0; wrData = 0; rdSelA = 0; rdSelB = 3;
        bValid = 0; bOp = 0; bDst = 0; bSrc = 0; bData = 0; bRdA = 1; bRdB = 2;
        modelReset();
        #1;
        checkOutput("resetA", 32'(rdDataA), 32'h00);
        checkOutput("resetS", 32'(rdDataB), 32'hFD);
        checkOutput("resetFlags", {27'd0, flagUpd, flagZ, flagN, spWrap, opErr}, 32'd0);
        checkOutput("resetSmallSp", 32'(bRdDataB), 32'hFD);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        checkEn = 1'b1;

        applyStimulus(1, 3'd1, 2'd0, 2'd0, 8'h80, 2'd0, 2'd3);
        checkOutput("litLoadA", 32'(rdDataA), 32'h80);
        checkOutput("litLoadFlags", {29'd0, flagUpd, flagZ, flagN}, 32'b101);
        applyStimulus(1, 3'd2, 2'd1, 2'd0, 8'h00, 2'd1, 2'd0);
        checkOutput("litXferX", 32'(rdDataA), 32'h80);
        checkOutput("litXferFlags", {29'd0, flagUpd, flagZ, flagN}, 32'b101);
        applyStimulus(1, 3'd1, 2'd1, 2'd0, 8'h01, 2'd1, 2'd0);
        applyStimulus(1, 3'd4, 2'd1, 2'd0, 8'h00, 2'd1, 2'd0);
        checkOutput("litDecTo0", 32'(rdDataA), 32'h00);
        checkOutput("litDecZ", {29'd0, flagUpd, flagZ, flagN}, 32'b110);
        applyStimulus(1, 3'd4, 2'd1, 2'd0, 8'h00, 2'd1, 2'd0);
        checkOutput("litDecToFF", 32'(rdDataA), 32'hFF);
        checkOutput("litDecN", {28'd0, flagUpd, flagZ, flagN, spWrap}, 32'b1010);
        applyStimulus(1, 3'd1, 2'd3, 2'd0, 8'h00, 2'd3, 2'd0);
        applyStimulus(1, 3'd5, 2'd0, 2'd0, 8'h00, 2'd3, 2'd0);
        checkOutput("litPushS", 32'(rdDataA), 32'hFF);
        checkOutput("litPushFlags", {28'd0, flagUpd, flagZ, flagN, spWrap}, 32'b0101);
        applyStimulus(1, 3'd6, 2'd2, 2'd0, 8'h00, 2'd3, 2'd0);
        checkOutput("litPopS", 32'(rdDataA), 32'h00);
        checkOutput("litPopWrap", 32'(spWrap), 32'd1);
        applyStimulus(1, 3'd1, 2'd1, 2'd0, 8'h00, 2'd1, 2'd3);
        applyStimulus(1, 3'd1, 2'd0, 2'd0, 8'h05, 2'd1, 2'd3);
        applyStimulus(1, 3'd2, 2'd3, 2'd1, 8'h00, 2'd1, 2'd3);
        checkOutput("litTxsS", 32'(rdDataB), 32'h00);
        checkOutput("litTxsFlags", {29'd0, flagUpd, flagZ, flagN}, 32'b000);
        applyStimulus(1, 3'd7, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
        checkOutput("litRsvdErr", 32'(opErr), 32'd1);
        applyStimulus(1, 3'd0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
        checkOutput("litNopErr", {30'd0, opErr, flagUpd}, 32'd0);

        // Small bank: index 3 does not exist, so ops naming it are rejected.
        bValid = 1; bOp = 3'd1; bDst = 2'd1; bData = 8'h80;
        applyStimulus(0, 3'd0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd3);
        checkOutput("smallLoad", 32'(bRdDataA), 32'h80);
        checkOutput("smallLoadFlags", {28'd0, bFlagUpd, bFlagZ, bFlagN, bOpErr}, 32'b1010);
        bOp = 3'd1; bDst = 2'd3; bData = 8'h11;
        applyStimulus(0, 3'd0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd3);
        checkOutput("smallBadLoadErr", {28'd0, bFlagUpd, bFlagZ, bFlagN, bOpErr}, 32'b0011);
        checkOutput("smallBadLoadRegs", {16'd0, bRdDataA, bRdDataB}, {16'd0, 8'h80, 8'hFD});
        bOp = 3'd2; bDst = 2'd0; bSrc = 2'd3; bRdA = 2'd0;
        applyStimulus(0, 3'd0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd3);
        checkOutput("smallBadXferErr", 32'(bOpErr), 32'd1);
        checkOutput("smallBadXferA", 32'(bRdDataA), 32'h00);
        bValid = 0;
        applyStimulus(0, 3'd0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd3);
        checkOutput("smallErrClears", 32'(bOpErr), 32'd0);

        for (int k = 0; k < 400; k++) begin
            o = 3'($urandom_range(0, 7));
            d = 2'($urandom_range(0, 3));
            data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) data = picks[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) begin
                o = 3'd1; d = 2'd3; data = picks[$urandom_range(0, 1)];
            end
            applyStimulus($urandom_range(0, 9) != 0, o, d, 2'($urandom_range(0, 3)), data,
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (k == 200) begin
                opValid = 1; op = 3'd1; dstSel = 2'd0; wrData = 8'hAA;
                rdSelA = 2'd0; rdSelB = 2'd3;
                #2;
                rst = 1'b1;
                modelReset();
                #1;
                checkOutput("asyncRstA", 32'(rdDataA), 32'h00);
                checkOutput("asyncRstS", 32'(rdDataB), 32'hFD);
                checkOutput("asyncRstFlags", {27'd0, flagUpd, flagZ, flagN, spWrap, opErr}, 32'd0);
                rdSelA = 2'd1; rdSelB = 2'd2;
                #1;
                checkOutput("asyncRstXY", {16'd0, rdDataA, rdDataB}, 32'd0);
                @(posedge clk);
                @(negedge clk);
                #1;
                rst = 1'b0;
                opValid = 0;
            end
        end

        checkEn = 1'b0;
        $display("[TB] %0d comparisons made", nChecks);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
        $finish;
    end

endmodule
